// File: rtl/fa_nibble_sequencer.sv
// Feeds wide operand pairs through an external 4-bit full adder one nibble at a time,
// LSB nibble first, chaining carry-out back into carry-in and assembling the wide result.
module fa_nibble_sequencer #(
    parameter int NIBBLES       = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 busy
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     a_reg, b_reg;
    logic [IDX_W-1:0] nib_reg;
    logic [IDX_W-1:0] nib_inc;
    logic [CNT_W-1:0] settle_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic [3:0]       add_a_reg, add_b_reg;
    logic             add_cin_reg;
    logic [3:0]       a_nib   [NIBBLES];
    logic [3:0]       b_nib   [NIBBLES];
    logic [3:0]       sum_nib [NIBBLES];
    logic             accept, capture, last_settle, last_nib;

    assign last_settle = (settle_reg == CNT_W'(SETTLE_CYCLES - 1));
    assign last_nib    = (nib_reg == IDX_W'(NIBBLES - 1));
    assign nib_inc     = nib_reg + IDX_W'(1);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                capture = last_settle;
                if (last_settle && last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            nib_reg     <= '0;
            settle_reg  <= '0;
            carry_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            add_a_reg   <= '0;
            add_b_reg   <= '0;
            add_cin_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg       <= in_a;
                b_reg       <= in_b;
                nib_reg     <= '0;
                settle_reg  <= '0;
                add_a_reg   <= in_a[3:0];
                add_b_reg   <= in_b[3:0];
                add_cin_reg <= in_cin;
            end else if (state_reg == DRIVE) begin
                if (last_settle) begin
                    settle_reg <= '0;
                    carry_reg  <= add_cout;
                    if (last_nib) begin
                        ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
                    end else begin
                        // Next nibble goes out on the same edge, chained on the fresh carry.
                        nib_reg     <= nib_inc;
                        add_a_reg   <= a_nib[nib_inc];
                        add_b_reg   <= b_nib[nib_inc];
                        add_cin_reg <= add_cout;
                    end
                end else begin
                    settle_reg <= settle_reg + CNT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi]          = a_reg[4*gi +: 4];
        assign b_nib[gi]          = b_reg[4*gi +: 4];
        assign out_sum[4*gi +: 4] = sum_nib[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_nib[gi] <= '0;
            end else if (capture && (nib_reg == IDX_W'(gi))) begin
                sum_nib[gi] <= add_sum;
            end
        end
    end

    assign add_a    = add_a_reg;
    assign add_b    = add_b_reg;
    assign add_cin  = add_cin_reg;
    assign out_cout = carry_reg;
    assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_fa_nibble_sequencer.sv
// Bench for fa_nibble_sequencer: a 16-bit default instance and an 8-bit, 3-cycle-settle
// instance, each wired to a behavioural 4-bit adder, checked against tables and a model.
module tb_fa_nibble_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, out_ready, in_cin;
    logic [15:0] in_a, in_b;
    int          sel;

    // Default instance (NIBBLES=4, SETTLE_CYCLES=1)
    logic        v1, r1, ac1, aco1, ov1, rdy1, oc1, oo1, busy1;
    logic [3:0]  aa1, ab1, as1;
    logic [15:0] os1;
    // Narrow, slow instance (NIBBLES=2, SETTLE_CYCLES=3)
    logic        v2, r2, ac2, aco2, ov2, rdy2, oc2, oo2, busy2;
    logic [3:0]  aa2, ab2, as2;
    logic [7:0]  os2;

    assign v1   = in_valid && (sel == 0);
    assign v2   = in_valid && (sel == 1);
    assign rdy1 = out_ready && (sel == 0);
    assign rdy2 = out_ready && (sel == 1);
    assign {aco1, as1} = {1'b0, aa1} + {1'b0, ab1} + {4'b0, ac1};
    assign {aco2, as2} = {1'b0, aa2} + {1'b0, ab2} + {4'b0, ac2};

    fa_nibble_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_sum(as1), .add_cout(aco1),
        .out_valid(ov1), .out_ready(rdy1), .out_sum(os1), .out_cout(oc1),
        .out_ovf(oo1), .busy(busy1)
    );

    fa_nibble_sequencer #(.NIBBLES(2), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin),
        .add_a(aa2), .add_b(ab2), .add_cin(ac2), .add_sum(as2), .add_cout(aco2),
        .out_valid(ov2), .out_ready(rdy2), .out_sum(os2), .out_cout(oc2),
        .out_ovf(oo2), .busy(busy2)
    );

    logic        m_valid, m_in_ready, m_cout, m_ovf, m_busy, m_add_cin;
    logic [15:0] m_sum;
    logic [3:0]  m_add_a;
    assign m_valid    = (sel == 1) ? ov2 : ov1;
    assign m_in_ready = (sel == 1) ? r2 : r1;
    assign m_sum      = (sel == 1) ? {8'h00, os2} : os1;
    assign m_cout     = (sel == 1) ? oc2 : oc1;
    assign m_ovf      = (sel == 1) ? oo2 : oo1;
    assign m_busy     = (sel == 1) ? busy2 : busy1;
    assign m_add_a    = (sel == 1) ? aa2 : aa1;
    assign m_add_cin  = (sel == 1) ? ac2 : ac1;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] seq_a   [16];
    logic       seq_cin [16];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide addition over the configured width.
    typedef struct { int sum; int cout; int ovf; } ref_t;
    function automatic ref_t ref_add(input int nib, input int a, input int b, input int cin);
        ref_t r;
        int w    = 4 * nib;
        int mask = (1 << w) - 1;
        int full = (a & mask) + (b & mask) + cin;
        int sa   = (a >> (w - 1)) & 1;
        int sb   = (b >> (w - 1)) & 1;
        r.sum  = full & mask;
        r.cout = (full >> w) & 1;
        r.ovf  = ((sa == sb) && (((r.sum >> (w - 1)) & 1) != sa)) ? 1 : 0;
        return r;
    endfunction

    // One full transaction on the selected instance; hold = backpressure cycles in DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int hold, output int s, output int c, output int o);
        int lat;
        int exp_lat = (sel == 1) ? 6 : 4;
        check("in_ready_idle", int'(m_in_ready), 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        step();
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_cin   = 1'($urandom);
        lat = 0;
        while (!m_valid && lat < 40) begin
            if (lat < 16) begin
                seq_a[lat]   = m_add_a;
                seq_cin[lat] = m_add_cin;
            end
            step();
            lat++;
        end
        check("latency", lat, exp_lat);
        s = int'(m_sum);
        c = int'(m_cout);
        o = int'(m_ovf);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom);
            step();
            check("bp_valid", int'(m_valid), 1);
            check("bp_sum", int'(m_sum), s);
            check("bp_in_ready", int'(m_in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_clear", int'(m_valid), 0);
        check("in_ready_back", int'(m_in_ready), 1);
        check("idle_after_hs", int'(m_busy), 0);
        $display("op inst=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 sel, a, b, cin, s, c, o, lat);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        int          sum;
        int          cout;
        int          ovf;
    } vec_t;

    vec_t vecs [7];
    int   s, c, o;
    ref_t r;

    initial begin
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 'h2233, 0, 0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 'h0000, 1, 0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 'h8000, 0, 1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 'h0000, 1, 1};
        vecs[4] = '{16'h0001, 16'h0001, 1'b0, 'h0002, 0, 0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 'h0001, 0, 0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 'hFFFF, 1, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_cin = 1'b0;
        in_a = '0; in_b = '0; sel = 0;
        step();
        step();
        check("rst_in_ready", int'(r1), 1);
        check("rst_add_a", int'(aa1), 0);
        check("rst_add_b", int'(ab1), 0);
        check("rst_add_cin", int'(ac1), 0);
        check("rst_out_valid", int'(ov1), 0);
        check("rst_out_sum", int'(os1), 0);
        check("rst_out_cout", int'(oc1), 0);
        check("rst_out_ovf", int'(oo1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst2_out_valid", int'(ov2), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, (i == 2) ? 5 : 0, s, c, o);
            check("vec_sum", s, vecs[i].sum);
            check("vec_cout", c, vecs[i].cout);
            check("vec_ovf", o, vecs[i].ovf);
            if (i == 0) begin
                check("seq_a0", int'(seq_a[0]), 4);
                check("seq_a1", int'(seq_a[1]), 3);
                check("seq_a2", int'(seq_a[2]), 2);
                check("seq_a3", int'(seq_a[3]), 1);
            end
            if (i == 1) begin
                check("seq_cin0", int'(seq_cin[0]), 0);
                check("seq_cin1", int'(seq_cin[1]), 1);
                check("seq_cin2", int'(seq_cin[2]), 1);
                check("seq_cin3", int'(seq_cin[3]), 1);
            end
        end

        // Reset during an operation, after two nibbles have been captured.
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0FFF; in_cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("midop_busy", int'(busy1), 1);
        check("midop_partial", int'(os1[7:0]), 'h33);
        rst_n = 1'b0;
        #1;
        check("arst_add_a", int'(aa1), 0);
        check("arst_add_b", int'(ab1), 0);
        check("arst_add_cin", int'(ac1), 0);
        check("arst_out_sum", int'(os1), 0);
        check("arst_out_cout", int'(oc1), 0);
        check("arst_busy", int'(busy1), 0);
        check("arst_in_ready", int'(r1), 1);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("no_valid_after_rst", int'(ov1), 0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0, s, c, o);
        check("post_rst_sum", s, 'h0002);

        for (int k = 0; k < 30; k++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            r  = ref_add(4, int'(ra), int'(rb), int'(rc));
            run_op(ra, rb, rc, int'($urandom_range(0, 2)), s, c, o);
            check("rnd_sum", s, r.sum);
            check("rnd_cout", c, r.cout);
            check("rnd_ovf", o, r.ovf);
        end

        sel = 1;
        step();
        run_op(16'h0000, 16'h0000, 1'b1, 0, s, c, o);
        check("n2_sum", s, 'h01);
        check("n2_cout", c, 0);
        check("n2_ovf", o, 0);
        run_op(16'h0021, 16'h0000, 1'b0, 1, s, c, o);
        check("n2b_sum", s, 'h21);
        for (int k = 0; k < 6; k++) begin
            check("n2_hold_a", int'(seq_a[k]), (k < 3) ? 1 : 2);
        end
        for (int k = 0; k < 20; k++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = {8'h00, 8'($urandom)};
            rb = {8'h00, 8'($urandom)};
            rc = 1'($urandom);
            r  = ref_add(2, int'(ra), int'(rb), int'(rc));
            run_op(ra, rb, rc, int'($urandom_range(0, 2)), s, c, o);
            check("n2_rnd_sum", s, r.sum);
            check("n2_rnd_cout", c, r.cout);
            check("n2_rnd_ovf", o, r.ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
